// File: rtl/rv32_pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush, stall and a saturating count of entries discarded by flush.
// When nothing valid is held the output payload is forced to NOP_VAL so downstream
// logic always sees a legal bubble.
module rv32_pipe_skid_stage #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID    = 1'b1,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_drops
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic [CNT_W-1:0]  drops_q, drops_d;
  logic [CNT_W:0]    drops_sum;

  logic main_full, skid_full;
  logic push, pop;
  logic load_main_in, load_main_skid, load_skid;

  assign main_full = (state_q != StEmpty);
  assign skid_full = (state_q == StTwo);

  // Upstream handshake; with SKID=1 there is no path from out_ready to in_ready.
  always_comb begin
    if (SKID) begin
      in_ready = ~skid_full & ~stall & ~flush;
    end else begin
      in_ready = (~main_full | out_ready) & ~stall & ~flush;
    end
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Downstream view: head entry, or the NOP bundle when empty.
  always_comb begin
    out_valid = main_full;
    out_data  = main_full ? main_q : NOP_VAL;
  end

  // Occupancy decoded from the state.
  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StTwo:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next state and register load selects; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d      = StOne;
          load_main_in = 1'b1;
        end
      end
      StOne: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          // Only reachable with SKID=1; with SKID=0 a push here implies a pop.
          state_d   = StTwo;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          state_d        = StOne;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d        = StEmpty;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Saturating flush-drop accumulation of the pre-flush occupancy.
  always_comb begin
    drops_sum = {1'b0, drops_q} + (CNT_W+1)'(occupancy);
    drops_d   = drops_q;
    if (flush) begin
      drops_d = drops_sum[CNT_W] ? {CNT_W{1'b1}} : drops_sum[CNT_W-1:0];
    end
  end

  // Control state and counter; reset drops held entries without counting them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      drops_q <= drops_d;
    end
  end

  // Payload registers need no reset: validity lives in state_q and out_data is muxed.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign flush_drops = drops_q;

  a_no_two_without_skid: assert property (
    @(posedge clk) disable iff (!rst_n) (SKID || state_q != StTwo)
  );

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(state_q == StTwo && push)
  );

endmodule

// File: tb/tb_rv32_pipe_skid_stage.sv
// Bench for rv32_pipe_skid_stage: three instances (SKID=1/CNT_W=16, SKID=1/CNT_W=2,
// SKID=0/CNT_W=3) share one stimulus stream and are each compared every cycle to a
// queue-based model, plus directed scenarios with literal expectations.
module tb_rv32_pipe_skid_stage;

  localparam int unsigned DW  = 16;
  localparam logic [DW-1:0] NOP = 16'h0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          rdy [3];
  logic          ov  [3];
  logic [DW-1:0] od  [3];
  logic [1:0]    occ [3];
  logic [15:0]   drops_a;
  logic [1:0]    drops_b;
  logic [2:0]    drops_c;

  int  checks = 0;
  int  failures = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  rv32_pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occ[0]), .flush_drops(drops_a)
  );

  rv32_pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(1'b1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occ[1]), .flush_drops(drops_b)
  );

  rv32_pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(1'b0), .CNT_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(occ[2]), .flush_drops(drops_c)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mq [3][$];
  int            md [3];

  function automatic bit m_skid(input int i);
    return i != 2;
  endfunction

  function automatic int m_max(input int i);
    return (i == 0) ? 65535 : ((i == 1) ? 3 : 7);
  endfunction

  function automatic bit m_ready(input int i);
    if (stall || flush) return 1'b0;
    if (m_skid(i)) return mq[i].size() < 2;
    return (mq[i].size() == 0) || out_ready;
  endfunction

  function automatic logic [31:0] act_drops(input int i);
    if (i == 0) return 32'(drops_a);
    if (i == 1) return 32'(drops_b);
    return 32'(drops_c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        bit pu;
        bit po;
        int sum;
        pu = in_valid && m_ready(i);
        po = (mq[i].size() > 0) && out_ready;
        if (flush) begin
          sum   = md[i] + mq[i].size();
          md[i] = (sum > m_max(i)) ? m_max(i) : sum;
          mq[i].delete();
        end else begin
          if (po) void'(mq[i].pop_front());
          if (pu) mq[i].push_back(in_data);
        end
      end
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      md[i] = 0;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(m_ready(i)));
        check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(mq[i].size() > 0));
        check($sformatf("out_data[%0d]", i), 32'(od[i]),
              32'((mq[i].size() > 0) ? mq[i][0] : NOP));
        check($sformatf("occupancy[%0d]", i), 32'(occ[i]), 32'(mq[i].size()));
        check($sformatf("flush_drops[%0d]", i), act_drops(i), 32'(md[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit ordy, input bit st,
                       input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;
    check("reset_occ", 32'(occ[0]), 32'd0);
    check("reset_valid", 32'(ov[0]), 32'd0);
    check("reset_data", 32'(od[0]), 32'h0013);
    check("reset_ready", 32'(rdy[0]), 32'd1);
    check("reset_drops", act_drops(0), 32'd0);

    // Streaming
    drive(1, 16'h1, 1, 0, 0); step();
    check("stream_d1", 32'(od[0]), 32'h1);
    drive(1, 16'h2, 1, 0, 0); step();
    check("stream_d2", 32'(od[0]), 32'h2);
    check("stream_occ", 32'(occ[0]), 32'd1);
    drive(1, 16'h3, 1, 0, 0); step();
    check("stream_d3", 32'(od[0]), 32'h3);
    check("stream_rdy", 32'(rdy[0]), 32'd1);
    drive(0, 16'h0, 1, 0, 0); step();
    check("stream_drained", 32'(ov[0]), 32'd0);

    // Backpressure
    drive(1, 16'hA, 0, 0, 0); step();
    drive(1, 16'hB, 0, 0, 0); step();
    drive(0, 16'h0, 0, 0, 0); #1;
    check("bp_occ", 32'(occ[0]), 32'd2);
    check("bp_rdy", 32'(rdy[0]), 32'd0);
    check("bp_head", 32'(od[0]), 32'hA);
    check("bp_occ_noskid", 32'(occ[2]), 32'd1);
    drive(0, 16'h0, 1, 0, 0); step();
    check("bp_second", 32'(od[0]), 32'hB);
    step();
    check("bp_empty_valid", 32'(ov[0]), 32'd0);
    check("bp_empty_data", 32'(od[0]), 32'h0013);

    // Flush at full, repeated to saturate the narrow counter
    for (int k = 0; k < 4; k++) begin
      drive(1, 16'h10 + 16'(k), 0, 0, 0); step();
      drive(1, 16'h20 + 16'(k), 0, 0, 0); step();
      drive(1, 16'h30, 0, 0, 1); #1;
      check("flush_rdy", 32'(rdy[0]), 32'd0);
      check("flush_visible", 32'(od[0]), 32'(16'h10 + 16'(k)));
      step();
      drive(0, 16'h0, 0, 0, 0); #1;
      check("flush_occ", 32'(occ[0]), 32'd0);
      check("flush_data", 32'(od[0]), 32'h0013);
      check("flush_drops16", act_drops(0), 32'(2 * (k + 1)));
      check("flush_drops2", act_drops(1), (k == 0) ? 32'd2 : 32'd3);
    end
    check("flush_drops3", act_drops(2), 32'd4);

    // Stall bubbles
    drive(1, 16'h55, 0, 0, 0); step();
    drive(1, 16'h66, 1, 1, 0); #1;
    check("stall_rdy", 32'(rdy[0]), 32'd0);
    step();
    check("stall_bubble_v", 32'(ov[0]), 32'd0);
    check("stall_bubble_d", 32'(od[0]), 32'h0013);
    step();
    check("stall_rdy_hold", 32'(rdy[0]), 32'd0);
    drive(1, 16'h66, 1, 0, 0); #1;
    check("stall_release_rdy", 32'(rdy[0]), 32'd1);
    step();
    check("stall_after", 32'(od[0]), 32'h66);
    drive(0, 16'h0, 1, 0, 0); step();

    // SKID=0 combinational ready
    drive(1, 16'h77, 0, 0, 0); step();
    drive(1, 16'h78, 1, 0, 0); #1;
    check("noskid_comb_rdy", 32'(rdy[2]), 32'd1);
    drive(1, 16'h78, 0, 0, 0); #1;
    check("noskid_bp_rdy", 32'(rdy[2]), 32'd0);
    step(); step();
    check("noskid_occ_cap", 32'(occ[2]), 32'd1);
    drive(0, 16'h0, 1, 0, 0); step(); step(); step();

    // Randomized traffic
    repeat (3000) begin
      drive($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3);
      step();
    end
    drive(0, 16'h0, 1, 0, 0); step(); step(); step();

    // Asynchronous reset while full
    drive(1, 16'hC1, 0, 0, 0); step();
    drive(1, 16'hC2, 0, 0, 0); step();
    drive(0, 16'h0, 0, 0, 0);
    check("pre_reset_occ", 32'(occ[0]), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(ov[0]), 32'd0);
    check("async_data", 32'(od[0]), 32'h0013);
    check("async_occ", 32'(occ[0]), 32'd0);
    check("async_drops", act_drops(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
